// File: rtl/ipv4_rx_parser.sv
// Streaming IPv4 receive parser: collects a 5..MAX_IHL word header, checks sum and fields,
// holds the decoded header for the consumer, then passes the payload through with zero latency.
module ipv4_rx_parser #(
  parameter int MAX_IHL   = 15,
  parameter bit CHECK_TTL = 1'b1,
  parameter bit DROP_BAD  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        valid,
  output logic        invalid,
  output logic [3:0]  err_code,
  output logic [3:0]  version,
  output logic [3:0]  ihl,
  output logic [7:0]  type_of_svc,
  output logic [15:0] total_length,
  output logic [15:0] packet_identification,
  output logic [2:0]  flags,
  output logic [12:0] fragment_offset,
  output logic [7:0]  time_to_live,
  output logic [7:0]  protocol,
  output logic [15:0] header_chksum,
  output logic [31:0] source_ip_address,
  output logic [31:0] destination_ip_address,
  output logic [3:0]  opt_words,
  output logic [31:0] pl_data,
  output logic        pl_valid,
  output logic        pl_last,
  input  logic        pl_ready,
  output logic [2:0]  dbg_state
);

  // Handshake rule for every port pair: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, ready may depend on valid.

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_CHK  = 3'd1,
    S_OUT  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // One bit per IHL value that is accepted (5..MAX_IHL).
  localparam logic [15:0] IHL_OK = (16'hFFFF >> (15 - MAX_IHL)) & 16'hFFE0;

  state_t      state, state_nxt;
  logic [19:0] acc;
  logic [3:0]  cnt;
  logic [3:0]  err_work;
  logic        ended;
  logic [15:0] budget;

  logic [19:0] acc_base, acc_add;
  logic [16:0] fold1;
  logic [15:0] csum_final;
  logic [15:0] hdr_bytes, pay_bytes;
  logic [3:0]  err_chk;
  logic        bad_first, hdr_done, beat_xfer;

  assign beat_xfer = in_valid & in_ready;
  assign bad_first = (in_data[31:28] != 4'd4) || !IHL_OK[in_data[27:24]];
  assign hdr_done  = (cnt == ihl - 4'd1);

  // Partial end-around fold on every beat keeps the running sum inside 20 bits.
  assign acc_base   = (cnt == 4'd0) ? 20'd0 : acc;
  assign acc_add    = {4'd0, acc_base[15:0]} + {16'd0, acc_base[19:16]}
                    + {4'd0, in_data[31:16]} + {4'd0, in_data[15:0]};
  assign fold1      = {1'b0, acc[15:0]} + {13'd0, acc[19:16]};
  assign csum_final = fold1[15:0] + {15'd0, fold1[16]};

  assign hdr_bytes = {10'd0, ihl, 2'b00};
  assign pay_bytes = (total_length > hdr_bytes) ? total_length - hdr_bytes : 16'd0;
  assign err_chk   = err_work | {(total_length < hdr_bytes),
                                 (CHECK_TTL && (time_to_live == 8'd0)),
                                 (csum_final != 16'hFFFF), 1'b0};
  assign opt_words = (ihl >= 4'd5) ? ihl - 4'd5 : 4'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_HDR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    hdr_valid = 1'b0;
    pl_valid  = 1'b0;
    pl_last   = 1'b0;
    pl_data   = 32'd0;
    case (state)
      S_HDR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (cnt == 4'd0) begin
            if (bad_first)    state_nxt = in_last ? S_CHK : S_DROP;
            else if (in_last) state_nxt = S_CHK;
          end else if (in_last || hdr_done) begin
            state_nxt = S_CHK;
          end
        end
      end
      S_CHK: state_nxt = S_OUT;
      S_OUT: begin
        hdr_valid = 1'b1;
        if (hdr_ready) begin
          if (ended)                    state_nxt = S_HDR;
          else if (invalid && DROP_BAD) state_nxt = S_DROP;
          else if (pay_bytes == 16'd0)  state_nxt = S_DROP;
          else                          state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        // Once the byte budget is spent, trailing beats are swallowed up to in_last.
        if (budget != 16'd0) begin
          pl_valid = in_valid;
          in_ready = pl_ready;
          pl_data  = in_data;
          pl_last  = in_last || (budget <= 16'd4);
        end else begin
          in_ready = 1'b1;
        end
        if (in_valid && in_ready && in_last) state_nxt = S_HDR;
      end
      S_DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = S_HDR;
      end
      default: state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc                    <= '0;
      cnt                    <= '0;
      err_work               <= '0;
      ended                  <= 1'b0;
      budget                 <= '0;
      valid                  <= 1'b0;
      invalid                <= 1'b0;
      err_code               <= '0;
      version                <= '0;
      ihl                    <= '0;
      type_of_svc            <= '0;
      total_length           <= '0;
      packet_identification  <= '0;
      flags                  <= '0;
      fragment_offset        <= '0;
      time_to_live           <= '0;
      protocol               <= '0;
      header_chksum          <= '0;
      source_ip_address      <= '0;
      destination_ip_address <= '0;
    end else begin
      case (state)
        S_HDR: if (beat_xfer) begin
          acc   <= acc_add;
          ended <= in_last;
          cnt   <= (state_nxt == S_HDR) ? cnt + 4'd1 : 4'd0;
          if (cnt == 4'd0) begin
            version                <= in_data[31:28];
            ihl                    <= in_data[27:24];
            type_of_svc            <= in_data[23:16];
            total_length           <= in_data[15:0];
            packet_identification  <= '0;
            flags                  <= '0;
            fragment_offset        <= '0;
            time_to_live           <= '0;
            protocol               <= '0;
            header_chksum          <= '0;
            source_ip_address      <= '0;
            destination_ip_address <= '0;
            err_work               <= {in_last, 2'b00, bad_first};
          end else begin
            if (in_last && !hdr_done) err_work[3] <= 1'b1;
            case (cnt)
              4'd1: begin
                packet_identification <= in_data[31:16];
                flags                 <= in_data[15:13];
                fragment_offset       <= in_data[12:0];
              end
              4'd2: begin
                time_to_live  <= in_data[31:24];
                protocol      <= in_data[23:16];
                header_chksum <= in_data[15:0];
              end
              4'd3: source_ip_address      <= in_data;
              4'd4: destination_ip_address <= in_data;
              default: ;
            endcase
          end
        end
        S_CHK: begin
          err_code <= err_chk;
          valid    <= ~|err_chk;
          invalid  <= |err_chk;
        end
        S_OUT: if (hdr_ready) budget <= pay_bytes;
        S_PAY: if (beat_xfer && (budget != 16'd0))
          budget <= (budget > 16'd4) ? budget - 16'd4 : 16'd0;
        default: ;
      endcase
    end
  end

endmodule
